// File: rtl/pong_pkg.sv
// Shared types and default timing for the pong paddle input path.
package pong_pkg;

   // Per-channel auto-repeat state
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2,
      HELD   = 2'd3
   } rpt_state_e;

   // Defaults for a 25 MHz pixel_clk: 10 ms debounce, 250 ms first repeat, 50 ms repeat period
   localparam int DEF_DEBOUNCE_CYCLES = 250000;
   localparam int DEF_REPEAT_DELAY    = 6250000;
   localparam int DEF_REPEAT_PERIOD   = 1250000;

   // Channel indices into the button vector
   localparam int BTN_UP_L   = 0;
   localparam int BTN_DOWN_L = 1;
   localparam int BTN_UP_R   = 2;
   localparam int BTN_DOWN_R = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop sync, counter debounce, edge pulses, move pulse FSM.
module button_channel
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic pixel_clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_move
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic          stable_dly_q, stable_dly_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          move_q, move_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   rpt_state_e    state_q, state_d;
   logic          rise, fall;

   // Synchroniser, debounce and edge detection
   always_comb begin
      sync1_d      = btn_in;
      sync2_d      = sync1_q;
      stable_d     = stable_q;
      dcnt_d       = '0;
      stable_dly_d = stable_q;
      if (sync2_q != stable_q) begin
         if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
         else                                    dcnt_d   = dcnt_q + DW'(1);
      end
      rise      = stable_q & ~stable_dly_q;
      fall      = ~stable_q & stable_dly_q;
      press_d   = rise;
      release_d = fall;
   end

   // Move pulse FSM. rcnt reads 1 in the cycle of a move pulse, so comparing
   // against the full delay/period lands the next pulse exactly that many
   // cycles later. A falling stable level (seen one edge early via stable_d)
   // drops to IDLE so no move pulse is ever issued after the level falls.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      move_d  = 1'b0;
      if (!stable_d) begin
         state_d = IDLE;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: if (rise) begin
               move_d  = 1'b1;
               rcnt_d  = RW'(1);
               state_d = (REPEAT_EN != 0) ? DELAY : HELD;
            end
            DELAY: if (rcnt_q == RW'(REPEAT_DELAY)) begin
               move_d  = 1'b1;
               rcnt_d  = RW'(1);
               state_d = REPEAT;
            end else begin
               rcnt_d = rcnt_q + RW'(1);
            end
            REPEAT: if (rcnt_q == RW'(REPEAT_PERIOD)) begin
               move_d = 1'b1;
               rcnt_d = RW'(1);
            end else begin
               rcnt_d = rcnt_q + RW'(1);
            end
            HELD:    ;
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         dcnt_q       <= '0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         move_q       <= 1'b0;
         rcnt_q       <= '0;
         state_q      <= IDLE;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         dcnt_q       <= dcnt_d;
         press_q      <= press_d;
         release_q    <= release_d;
         move_q       <= move_d;
         rcnt_q       <= rcnt_d;
         state_q      <= state_d;
      end
   end

   assign btn_level   = stable_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_move    = move_q;

endmodule

// File: rtl/button_conditioner.sv
// Vectorised conditioner for the paddle buttons: one independent channel per bit.
module button_conditioner
   import pong_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic             pixel_clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_move
);

   // One channel instance per button, no cross-channel interaction
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .pixel_clk   (pixel_clk),
         .reset       (reset),
         .btn_in      (btn_in[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_move    (btn_move[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3).
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_in, btn_in2;
   logic [3:0] lvl, prs, rel, mov;
   logic [3:0] lvl2, prs2, rel2, mov2;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_conditioner #(.N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
                        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
      .pixel_clk(clk), .reset(reset), .btn_in(btn_in),
      .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_move(mov));

   button_conditioner #(.N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
                        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut_nr (
      .pixel_clk(clk), .reset(reset), .btn_in(btn_in2),
      .btn_level(lvl2), .btn_press(prs2), .btn_release(rel2), .btn_move(mov2));

   typedef struct {
      logic [3:0] btn;
      logic [3:0] lvl, prs, rel, mov;
   } vec_t;

   vec_t tbl [32];

   task automatic chk(input string nm, input int cyc, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int cyc, input logic [3:0] el, input logic [3:0] ep,
                          input logic [3:0] er, input logic [3:0] em);
      chk({nm, ".level"}, cyc, lvl, el);
      chk({nm, ".press"}, cyc, prs, ep);
      chk({nm, ".release"}, cyc, rel, er);
      chk({nm, ".move"}, cyc, mov, em);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Move timing for a press whose input was first sampled at cycle 0:
   // press pulse at cycle 6, then +10, then every 3
   function automatic logic mv(input int c);
      return (c == 6) || (c >= 16 && ((c - 16) % 3) == 0);
   endfunction

   function automatic vec_t mk(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p,
                               input logic [3:0] r, input logic [3:0] m);
      vec_t v;
      v.btn = b; v.lvl = l; v.prs = p; v.rel = r; v.mov = m;
      return v;
   endfunction

   initial begin
      // glitch on ch0: 3 high, 2 low, 3 high, then quiet -- nothing may appear
      tbl[0]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[1]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[2]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[3]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[4]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[5]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[6]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[7]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[8]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[9]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[10] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[11] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[12] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[13] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      // real ch0 press for 8 cycles, then release before the first repeat
      tbl[14] = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[15] = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[16] = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[17] = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[18] = mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[19] = mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[20] = mk(4'h1, 4'h1, 4'h1, 4'h0, 4'h1);
      tbl[21] = mk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[22] = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[23] = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[24] = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[25] = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[26] = mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[27] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[28] = mk(4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
      tbl[29] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[30] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[31] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

      // ---- reset state
      reset = 1'b1; btn_in = 4'h0; btn_in2 = 4'h0;
      repeat (3) @(negedge clk);
      chk_all("rst_init", 0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("rst_init.nr_level", 0, lvl2, 4'h0);
      reset = 1'b0;
      repeat (3) step();

      // ---- reset asserted mid-cycle with all buttons held, then released
      @(posedge clk); #3;
      reset = 1'b1; btn_in = 4'hF;
      #1;
      chk_all("rst_hold", 0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_all("rst_hold", k, 4'h0, 4'h0, 4'h0, 4'h0);
      end
      reset = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk_all("rst_rel", k, (k >= 6) ? 4'hF : 4'h0, (k == 7) ? 4'hF : 4'h0,
                 4'h0, (k == 7) ? 4'hF : 4'h0);
      end
      btn_in = 4'h0;
      repeat (12) step();
      chk_all("rst_settle", 0, 4'h0, 4'h0, 4'h0, 4'h0);

      // ---- table: glitch rejection, then press/release on ch0
      for (int i = 0; i < 32; i++) begin
         btn_in = tbl[i].btn;
         step();
         chk_all("tbl", i, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].mov);
      end

      // ---- ch1 held 40 cycles (repeat timing), then dropped during REPEAT
      for (int c = 0; c < 56; c++) begin
         btn_in = (c < 40) ? 4'b0010 : 4'b0000;
         step();
         chk_all("rep1", c,
                 {2'b00, (c >= 5 && c < 45), 1'b0},
                 {2'b00, (c == 6), 1'b0},
                 {2'b00, (c == 46), 1'b0},
                 {2'b00, (c < 45) && mv(c), 1'b0});
      end

      // ---- REPEAT_EN=0 instance: ch2 held 50 cycles gives exactly one move
      begin
         int nmove = 0;
         for (int c = 0; c < 60; c++) begin
            btn_in2 = (c < 50) ? 4'b0100 : 4'b0000;
            step();
            if (mov2[2]) nmove++;
            chk("nr.level", c, lvl2, {1'b0, (c >= 5 && c < 55), 2'b00});
            chk("nr.press", c, prs2, {1'b0, (c == 6), 2'b00});
            chk("nr.release", c, rel2, {1'b0, (c == 56), 2'b00});
            chk("nr.move", c, mov2, {1'b0, (c == 6), 2'b00});
         end
         chk("nr.move_count", 0, nmove[3:0], 4'd1);
      end

      // ---- ch0 and ch3 staggered by 2 cycles
      for (int c = 0; c < 25; c++) begin
         if (c == 0) btn_in[0] = 1'b1;
         if (c == 2) btn_in[3] = 1'b1;
         step();
         chk_all("stag", c,
                 {(c >= 7), 2'b00, (c >= 5)},
                 {(c == 8), 2'b00, (c == 6)},
                 4'h0,
                 {mv(c - 2), 2'b00, mv(c)});
      end

      // ---- one-cycle reset mid-hold: outputs cut at once, timing restarts
      reset = 1'b1;
      #1;
      chk_all("midrst", 0, 4'h0, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk_all("repress", c,
                 {(c >= 5), 2'b00, (c >= 5)},
                 {(c == 6), 2'b00, (c == 6)},
                 4'h0,
                 {mv(c), 2'b00, mv(c)});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
